// File: rtl/tcb_pkg.sv
// Shared types and default geometry for the TCB image feeder.
// State encoding, image sizing defaults and the counter-width helper.
package tcb_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FIRE   = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam int DEF_N_PIX   = 121;
  localparam int DEF_PIX_W   = 8;
  localparam int DEF_IMG_W   = 1024;
  localparam int DEF_RES_W   = 32;
  localparam int DEF_TIMEOUT = 65535;
  localparam int IMG_USED    = DEF_N_PIX * DEF_PIX_W;

  // Never returns 0 so a single-entry range still gets a 1-bit counter.
  function automatic int CNT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcb_img_feeder_if.sv
// Feeder bus: byte stream in, flat image / start strobe to the classifier, result out.
// master = feeder side, slave = host + classifier side.
interface tcb_img_feeder_if #(
  parameter int PIX_W = tcb_pkg::DEF_PIX_W,
  parameter int IMG_W = tcb_pkg::DEF_IMG_W,
  parameter int RES_W = tcb_pkg::DEF_RES_W
);
  logic [PIX_W-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [IMG_W-1:0] img_source;
  logic             valid_top;
  logic             ready_top;
  logic [RES_W-1:0] number;
  logic [RES_W-1:0] res_data;
  logic             res_err;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  modport master (
    input  s_data, s_valid, ready_top, number, res_ready,
    output s_ready, img_source, valid_top, res_data, res_err, res_valid, busy
  );

  modport slave (
    output s_data, s_valid, ready_top, number, res_ready,
    input  s_ready, img_source, valid_top, res_data, res_err, res_valid, busy
  );
endinterface

// File: rtl/tcb_pix_packer.sv
// Byte-addressed image register: one pixel written per enabled cycle, clear wins over write.
// Write lands on the next edge; no backpressure, the caller gates wr_en.
module tcb_pix_packer #(
  parameter int N_PIX = tcb_pkg::DEF_N_PIX,
  parameter int PIX_W = tcb_pkg::DEF_PIX_W,
  parameter int IMG_W = tcb_pkg::DEF_IMG_W,
  parameter int IDX_W = tcb_pkg::CNT_W(N_PIX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [PIX_W-1:0] wr_dat,
  input  logic             clr,
  output logic [IMG_W-1:0] img
);

  logic [N_PIX-1:0][PIX_W-1:0] pix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix <= '0;
    end else if (clr) begin
      pix <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < N_PIX; i++) begin
        if (wr_idx == IDX_W'(i)) pix[i] <= wr_dat;
      end
    end
  end

  // Unused top bits of the flat image are tied to zero.
  generate
    if (IMG_W > N_PIX * PIX_W) begin : g_pad
      assign img = {{(IMG_W - N_PIX * PIX_W){1'b0}}, pix};
    end else begin : g_exact
      assign img = pix;
    end
  endgenerate

endmodule

// File: rtl/tcb_img_feeder.sv
// Loads a byte-serial image, fires the classifier once, returns its class (or a timeout) on a result port.
// Latency 1 cycle per hop (last pixel->valid_top, ready_top->res_valid, res handshake->s_ready); one image in flight.
module tcb_img_feeder
  import tcb_pkg::*;
#(
  parameter int N_PIX   = DEF_N_PIX,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  tcb_img_feeder_if.master bus
);

  localparam int IDX_W = CNT_W(N_PIX);
  localparam int WC_W  = CNT_W(TIMEOUT + 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] pix_cnt;
  logic [WC_W-1:0]  wait_cnt;
  logic [RES_W-1:0] res_data;
  logic             res_err;
  logic             res_valid;
  logic             load_hs, last_pix, timed_out, res_hs;

  assign load_hs  = (state == LOAD) && bus.s_valid;
  assign last_pix = (pix_cnt == IDX_W'(N_PIX - 1));
  // Timeout is declared on the cycle the counter steps onto TIMEOUT-1.
  assign timed_out = (wait_cnt == WC_W'(TIMEOUT - 2));
  assign res_hs   = (state == RESULT) && bus.res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_hs && last_pix) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      WAIT:    if (bus.ready_top || timed_out) state_nxt = RESULT;
      RESULT:  if (bus.res_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    bus.s_ready   = 1'b0;
    bus.valid_top = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      LOAD: begin
        bus.s_ready = 1'b1;
        bus.busy    = (pix_cnt != '0);
      end
      FIRE:    bus.valid_top = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt   <= '0;
      wait_cnt  <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (load_hs) pix_cnt <= last_pix ? '0 : pix_cnt + IDX_W'(1);

      if (state == FIRE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && wait_cnt != WC_W'(TIMEOUT - 1)) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end

      // ready_top wins when it coincides with the timeout.
      if (state == WAIT) begin
        if (bus.ready_top) begin
          res_data  <= bus.number;
          res_err   <= 1'b0;
          res_valid <= 1'b1;
        end else if (timed_out) begin
          res_data  <= '0;
          res_err   <= 1'b1;
          res_valid <= 1'b1;
        end
      end else if (res_hs) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.res_data  = res_data;
  assign bus.res_err   = res_err;
  assign bus.res_valid = res_valid;

  tcb_pix_packer #(
    .N_PIX (N_PIX),
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IDX_W (IDX_W)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (load_hs),
    .wr_idx (pix_cnt),
    .wr_dat (bus.s_data),
    .clr    (res_hs),
    .img    (bus.img_source)
  );

endmodule

// File: tb/tb_tcb_img_feeder.sv
// Bench for tcb_img_feeder: table of directed transactions, reset abort sequence, then random transactions.
module tb_tcb_img_feeder;

  localparam int NP   = 121;
  localparam int PW   = 8;
  localparam int IW   = 1024;
  localparam int RW   = 32;
  localparam int TO   = 16;
  localparam int NONE = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tcb_img_feeder_if #(.PIX_W(PW), .IMG_W(IW), .RES_W(RW)) bus ();

  tcb_img_feeder #(
    .N_PIX(NP), .PIX_W(PW), .IMG_W(IW), .RES_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // d: cycle offset from the valid_top cycle at which ready_top is pulsed.
  typedef struct {
    int          d;
    logic [31:0] num;
    int          hold;
    bit          gap;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[7];
  logic [7:0]  pixels[NP];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic chk_img(input string nm, input logic [IW-1:0] req);
    int bad;
    bad = -1;
    checks++;
    if (bus.img_source !== req) begin
      failures++;
      for (int i = 0; i < IW / 8; i++)
        if (bad < 0 && bus.img_source[i*8 +: 8] !== req[i*8 +: 8]) bad = i;
      $display("FAIL %s byte=%0d actual=0x%0h required=0x%0h", nm, bad,
               bus.img_source[bad*8 +: 8], req[bad*8 +: 8]);
    end
  endtask

  function automatic logic [IW-1:0] packed_image();
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*PW +: PW] = pixels[i];
    return r;
  endfunction

  // Feeds pixels[0..upto-1]; counts only real handshakes.
  task automatic load(input bit gap, input int upto, output bit ok);
    int n;
    int cyc;
    bit v;
    bit sr;
    n   = 0;
    cyc = 0;
    while (n < upto && cyc < 2000) begin
      v = gap ? ((cyc % 2) == 0) : 1'b1;
      bus.s_valid = v;
      bus.s_data  = v ? pixels[n] : 8'($urandom);
      sr = bus.s_ready;
      tick();
      if (v && sr) n++;
      cyc++;
    end
    bus.s_valid = 1'b0;
    ok = (n == upto);
    chk("load_count", n, upto);
  endtask

  task automatic run_txn(input vec_t v);
    bit            ok;
    bit            got;
    int            c;
    logic [IW-1:0] exp_img;
    load(v.gap, NP, ok);
    if (!ok) return;
    exp_img = packed_image();
    chk("fire_s_ready", 32'(bus.s_ready), 0);
    chk("fire_valid_top", 32'(bus.valid_top), 1);
    chk("fire_busy", 32'(bus.busy), 1);
    chk_img("img_packed", exp_img);

    c   = 0;
    got = 1'b0;
    while (c < 40 && !got) begin
      bus.ready_top = (c == v.d);
      bus.number    = (c == v.d) ? v.num : $urandom;
      bus.s_valid   = 1'($urandom);
      bus.s_data    = 8'($urandom);
      tick();
      c++;
      if (c == 1) chk("valid_top_single", 32'(bus.valid_top), 0);
      if (bus.res_valid) got = 1'b1;
    end
    bus.ready_top = 1'b0;
    bus.s_valid   = 1'b0;
    chk("res_latency", got ? c : -1, v.exp_lat);
    if (!got) return;
    chk("res_data", bus.res_data, v.exp_data);
    chk("res_err", 32'(bus.res_err), 32'(v.exp_err));
    chk_img("img_held", exp_img);

    for (int h = 0; h < v.hold; h++) begin
      bus.ready_top = 1'($urandom);
      bus.number    = $urandom;
      bus.s_valid   = 1'b1;
      bus.s_data    = 8'($urandom);
      bus.res_ready = 1'b0;
      tick();
      chk("hold_res_valid", 32'(bus.res_valid), 1);
      chk("hold_res_data", bus.res_data, v.exp_data);
      chk("hold_res_err", 32'(bus.res_err), 32'(v.exp_err));
      chk("hold_s_ready", 32'(bus.s_ready), 0);
    end
    if (v.hold > 0) chk_img("img_hold_end", exp_img);

    bus.ready_top = 1'b0;
    bus.s_valid   = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("back_s_ready", 32'(bus.s_ready), 1);
    chk("back_res_valid", 32'(bus.res_valid), 0);
    chk("back_busy", 32'(bus.busy), 0);
    chk_img("img_cleared", '0);
  endtask

  initial begin
    vec_t rv;
    bit   ok;
    int   d;

    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.ready_top = 1'b0;
    bus.number    = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    chk("rst_s_ready", 32'(bus.s_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid_top", 32'(bus.valid_top), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_err", 32'(bus.res_err), 0);
    chk("rst_res_data", bus.res_data, 0);
    chk_img("rst_img", '0);

    //           d     num           hold gap exp_data      err lat
    vecs[0] = '{5,    32'd7,        0,   0,  32'd7,        0,  6};
    vecs[1] = '{1,    32'd3,        10,  0,  32'd3,        0,  2};
    vecs[2] = '{NONE, 32'd9,        0,   0,  32'd0,        1,  16};
    vecs[3] = '{15,   32'h55,       0,   1,  32'h55,       0,  16};
    vecs[4] = '{0,    32'h11,       2,   1,  32'd0,        1,  16};
    vecs[5] = '{13,   32'h1234,     1,   0,  32'h1234,     0,  14};
    vecs[6] = '{14,   32'hdeadbeef, 0,   1,  32'hdeadbeef, 0,  15};

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < NP; j++) pixels[j] = (i == 0) ? 8'(j) : 8'(j * 7 + i * 13);
      run_txn(vecs[i]);
    end

    // Reset in the middle of a load aborts the image.
    for (int j = 0; j < NP; j++) pixels[j] = 8'($urandom);
    load(1'b0, 60, ok);
    chk("mid_busy", 32'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_valid_top", 32'(bus.valid_top), 0);
    chk("arst_res_valid", 32'(bus.res_valid), 0);
    chk("arst_s_ready", 32'(bus.s_ready), 1);
    chk_img("arst_img", '0);
    @(posedge clk);
    #3 rst = 1'b1;
    bus.ready_top = 1'b1;
    bus.number    = 32'd5;
    repeat (3) begin
      tick();
      chk("stray_ready_res_valid", 32'(bus.res_valid), 0);
      chk("stray_ready_busy", 32'(bus.busy), 0);
    end
    bus.ready_top = 1'b0;
    for (int j = 0; j < NP; j++) pixels[j] = 8'(255 - j);
    run_txn(vecs[0]);

    // Random transactions against the timing rules: ready_top counts only in
    // the TO-1 cycles following valid_top; otherwise the timeout lands TO cycles after it.
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < NP; j++) pixels[j] = 8'($urandom);
      d       = int'($urandom_range(0, 20));
      rv.d    = d;
      rv.num  = $urandom;
      rv.hold = int'($urandom_range(0, 3));
      rv.gap  = 1'($urandom);
      if (d >= 1 && d <= TO - 1) begin
        rv.exp_data = rv.num;
        rv.exp_err  = 1'b0;
        rv.exp_lat  = d + 1;
      end else begin
        rv.exp_data = '0;
        rv.exp_err  = 1'b1;
        rv.exp_lat  = TO;
      end
      run_txn(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcb_img_feeder.md
Name: tcb_img_feeder

Overview:
- Host-side driver for the TCB classifier top: receives an image as a byte-serial valid/ready stream and assembles it into the flat img_source vector.
- Issues one valid_top pulse to the classifier, waits for ready_top, captures the predicted class and returns it on a valid/ready result port.
- Sits between the host/DMA byte stream and the classifier top; one image is in flight at a time.

Parameters:
- N_PIX, 121, pixels per image.
- PIX_W, 8, bits per pixel.
- IMG_W, 1024, width of img_source; must satisfy IMG_W >= N_PIX*PIX_W.
- RES_W, 32, width of the classifier result.
- TIMEOUT, 65535, maximum cycles to wait for ready_top.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  PIX_W  pixel byte.
- s_valid  in  1  pixel valid.
- s_ready  out  1  feeder can accept a pixel.
- img_source  out  IMG_W  assembled image to classifier.
- valid_top  out  1  start strobe to classifier.
- ready_top  in  1  classifier done.
- number  in  RES_W  classifier prediction.
- res_data  out  RES_W  captured prediction.
- res_err  out  1  1 = timeout, res_data invalid (0).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- busy  out  1  high in any state other than LOAD with pix_cnt==0.

Behaviour:
- Reset (rst==0, asynchronous): state=LOAD, pix_cnt=0, img_source=0, valid_top=0, res_data=0, res_err=0, res_valid=0, wait counter=0, s_ready=1 after reset releases.
- State LOAD:
  - s_ready=1.
  - A handshake (s_valid&s_ready) writes s_data into img_source[pix_cnt*PIX_W +: PIX_W], so the first byte lands in [7:0].
  - After the write, pix_cnt increments.
  - On the handshake with pix_cnt==N_PIX-1, pix_cnt wraps to 0 and the next state is FIRE.
  - Bits [IMG_W-1:N_PIX*PIX_W] are always 0.
- State FIRE:
  - s_ready=0.
  - valid_top=1 for exactly this one cycle.
  - Next state is WAIT and the wait counter is cleared.
  - img_source must not change from FIRE until result capture.
- State WAIT:
  - s_ready=0.
  - The wait counter increments each cycle.
  - ready_top is ignored in the FIRE cycle itself, and is sampled from the first WAIT cycle onward.
  - If ready_top==1: res_data<=number, res_err<=0, res_valid<=1, next state RESULT.
  - If the counter reaches TIMEOUT-1 without ready_top: res_data<=0, res_err<=1, res_valid<=1, next state RESULT.
  - If ready_top and timeout coincide in the same cycle, ready_top wins.
- State RESULT:
  - s_ready=0.
  - res_valid, res_data and res_err are held stable until res_ready==1.
  - On res_valid&res_ready: res_valid<=0, img_source<=0, next state LOAD.
  - ready_top pulses or levels arriving in RESULT are ignored.
- Latency:
  - Last pixel handshake to valid_top high: 1 cycle.
  - Returned ready_top to res_valid high: 1 cycle.
  - res_valid&res_ready to s_ready high: 1 cycle.
- s_valid is ignored whenever s_ready==0; no pixel is dropped or double-written.
- Reset asserted mid-load or mid-wait aborts the image; all state returns to reset values. A classifier response arriving after reset release, while in LOAD, is ignored.
- Wait counter width: clog2(TIMEOUT+1), saturating at TIMEOUT-1.

Decomposition:
- Shared package tcb_pkg holds:
  - the state enum (LOAD, FIRE, WAIT, RESULT);
  - N_PIX/PIX_W/IMG_W defaults, with a localparam IMG_USED = N_PIX*PIX_W;
  - the CNT_W function (clog2).
- One natural sub-module, tcb_pix_packer: a byte-write register file with pixel index, write enable, clear and the flat image output. The FSM, timeout logic and result register stay in the top.

Test Plan:
- Load 121 bytes 0x00..0x78 with s_valid held high:
  - s_ready drops in the cycle after the 121st handshake;
  - img_source[7:0]=0x00 and img_source[967:960]=0x78, bits [1023:968]=0;
  - valid_top is high exactly 1 cycle.
- Drive ready_top 5 cycles after valid_top with number=7, res_ready=1:
  - res_valid=1, res_data=7, res_err=0 one cycle later;
  - s_ready=1 on the following cycle.
- Hold res_ready=0 for 10 cycles with number=3:
  - res_data stays 3 and res_valid stays 1;
  - a further ready_top pulse and s_valid=1 traffic change nothing.
- Never assert ready_top with TIMEOUT=16:
  - res_valid=1 with res_err=1 and res_data=0, 16 cycles after valid_top.
- Gapped input (s_valid toggling every other cycle):
  - exactly 121 writes occur with correct packing;
  - ready_top asserted on the same cycle the counter hits TIMEOUT-1 gives res_err=0.
- Pull rst low after 60 pixels:
  - immediately pix_cnt=0, img_source=0, valid_top=0, res_valid=0;
  - a fresh 121-pixel load then completes normally.
